// File: rtl/vnu_pipe_if.sv
// Handshake/data bundle between the check node array, the VNU pipeline and the message memory.
interface vnu_pipe_if #(
    parameter int unsigned DEGREE    = 3,
    parameter int unsigned IN_W      = 5,
    parameter int unsigned LLR_W     = 5,
    parameter int unsigned OUT_W     = 6,
    parameter int unsigned SAT_CNT_W = 8
);
    logic                      en;
    logic                      valid_in;
    logic [DEGREE*IN_W-1:0]    X;
    logic [LLR_W-1:0]          Z;
    logic                      clr_stats;
    logic                      valid_out;
    logic [DEGREE*OUT_W-1:0]   Y;
    logic                      hard_decision;
    logic                      sat_out;
    logic [SAT_CNT_W-1:0]      sat_count;

    modport master (
        output en, valid_in, X, Z, clr_stats,
        input  valid_out, Y, hard_decision, sat_out, sat_count
    );

    modport slave (
        input  en, valid_in, X, Z, clr_stats,
        output valid_out, Y, hard_decision, sat_out, sat_count
    );
endinterface

// File: rtl/vnu_pipe.sv
// Two-stage variable node unit: total LLR, per-edge extrinsic messages with saturation,
// hard decision and a saturating count of saturated beats.
module vnu_pipe #(
    parameter int unsigned DEGREE    = 3,
    parameter int unsigned IN_W      = 5,
    parameter int unsigned LLR_W     = 5,
    parameter int unsigned OUT_W     = 6,
    parameter int unsigned SAT_CNT_W = 8
) (
    input logic       clk,
    input logic       rst,
    vnu_pipe_if.slave bus
);
    localparam int unsigned MAX_W = (IN_W > LLR_W) ? IN_W : LLR_W;
    localparam int unsigned SW    = MAX_W + $clog2(DEGREE + 1) + 1;
    localparam logic signed [SW-1:0] Y_MAX = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

    logic signed [SW-1:0]     x_tc [DEGREE];
    logic signed [SW-1:0]     t_d;
    logic signed [SW-1:0]     x_q [DEGREE];
    logic signed [SW-1:0]     t_q;
    logic                     v1_q;

    logic signed [SW-1:0]     e [DEGREE];
    logic signed [SW-1:0]     e_neg [DEGREE];
    logic [DEGREE*OUT_W-1:0]  y_d, y_q;
    logic                     sat_d, sat_q;
    logic                     hd_q, v2_q;
    logic [SAT_CNT_W-1:0]     cnt_d, cnt_q;

    // Sign-magnitude to two's complement; negative zero collapses to 0 naturally.
    always_comb begin
        t_d = SW'(bus.Z[LLR_W-2:0]);
        if (bus.Z[LLR_W-1]) t_d = -t_d;
        for (int i = 0; i < DEGREE; i++) begin
            x_tc[i] = SW'(bus.X[i*IN_W +: IN_W-1]);
            if (bus.X[i*IN_W + IN_W - 1]) x_tc[i] = -x_tc[i];
            t_d = t_d + x_tc[i];
        end
    end

    always_comb begin
        y_d   = '0;
        sat_d = 1'b0;
        for (int i = 0; i < DEGREE; i++) begin
            e[i]     = t_q - x_q[i];
            e_neg[i] = -e[i];
            if (e[i] > Y_MAX) begin
                y_d[i*OUT_W +: OUT_W] = {1'b0, Y_MAX[OUT_W-2:0]};
                sat_d = 1'b1;
            end else if (e[i] < -Y_MAX) begin
                y_d[i*OUT_W +: OUT_W] = {1'b1, Y_MAX[OUT_W-2:0]};
                sat_d = 1'b1;
            end else if (e[i] < 0) begin
                y_d[i*OUT_W +: OUT_W] = {1'b1, e_neg[i][OUT_W-2:0]};
            end else begin
                y_d[i*OUT_W +: OUT_W] = {1'b0, e[i][OUT_W-2:0]};
            end
        end
    end

    // Count the beat as it enters stage 2, so sat_count moves on the same edge as sat_out.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.en && v1_q && sat_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        if (bus.clr_stats) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEGREE; i++) x_q[i] <= '0;
            t_q   <= '0;
            v1_q  <= 1'b0;
            y_q   <= '0;
            sat_q <= 1'b0;
            hd_q  <= 1'b0;
            v2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (bus.en) begin
                for (int i = 0; i < DEGREE; i++) x_q[i] <= x_tc[i];
                t_q   <= t_d;
                v1_q  <= bus.valid_in;
                y_q   <= y_d;
                sat_q <= sat_d;
                hd_q  <= t_q[SW-1];
                v2_q  <= v1_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.valid_out     = v2_q;
    assign bus.Y             = y_q;
    assign bus.hard_decision = hd_q;
    assign bus.sat_out       = sat_q;
    assign bus.sat_count     = cnt_q;
endmodule

// File: doc/vnu_pipe.md
Name: vnu_pipe

Overview:
- Parametrised, pipelined variable node unit for the LDPC decoder.
- Generalises the fixed 3-input VNU in four ways: configurable node degree and message widths, valid tracking, pipeline stall, and output saturation statistics.
- Sums the channel LLR with all incoming check-to-variable messages, returns per-edge extrinsic messages and a hard decision.
- Sits between the check node array and the message memory.

Parameters:
- DEGREE, 3, number of incoming check messages (≥2)
- IN_W, 5, width of each incoming message X, sign-magnitude
- LLR_W, 5, width of channel LLR Z, sign-magnitude
- OUT_W, 6, width of each outgoing message Y, sign-magnitude
- SAT_CNT_W, 8, width of saturation event counter

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous active-high reset
- en  input  1  pipeline advance; 0 freezes all registers
- valid_in  input  1  X/Z carry a valid beat
- X  input  DEGREE*IN_W  incoming messages; message i at [i*IN_W +: IN_W]
- Z  input  LLR_W  channel LLR
- clr_stats  input  1  clears sat_count
- valid_out  output  1  Y/hard_decision valid
- Y  output  DEGREE*OUT_W  extrinsic messages; message i at [i*OUT_W +: OUT_W]
- hard_decision  output  1  1 when total LLR < 0
- sat_out  output  1  some Y in the current beat saturated
- sat_count  output  SAT_CNT_W  saturating count of beats with sat_out=1

Behaviour:
- Number format:
  - All messages are sign-magnitude; MSB = sign (1 = negative), remaining bits = magnitude.
  - Negative zero (sign=1, mag=0) is read as 0.
  - Outputs never produce negative zero.
- Internal arithmetic:
  - Two's complement, width SW = max(IN_W,LLR_W) + clog2(DEGREE+1) + 1.
  - No internal overflow is possible at this width.
- Stage 1 (registered on a clk edge with en=1):
  - Convert each X[i] and Z to two's complement.
  - Register the converted X[i], the total T = Z + ΣX[i], and valid_in.
- Stage 2 (registered on a clk edge with en=1):
  - E[i] = T − X[i].
  - Saturate E[i] to ±(2^(OUT_W−1)−1).
  - Convert to sign-magnitude and register into Y[i].
  - hard_decision = (T < 0). T = 0 gives 0.
  - sat_out = OR of per-edge saturation flags.
  - valid_out = stage-1 valid.
- Latency: 2 enabled clock edges, input beat to outputs. Throughput: 1 beat per enabled cycle.
- en=0: every pipeline register and sat_count holds its value. Outputs stay stable. Inputs are ignored.
- Y, hard_decision and sat_out update whenever en=1, whatever valid_in is. Consumers qualify them with valid_out.
- sat_count:
  - Increments by 1 on an enabled edge where the stage-2 result has valid=1 and saturation=1.
  - Holds at 2^SAT_CNT_W−1 and does not wrap.
  - clr_stats=1 zeroes it on the next clk edge, regardless of en. A clear and an increment on the same edge give 0.
- Reset:
  - rst=1 at a clk edge clears all pipeline registers, valid_out, Y, hard_decision, sat_out and sat_count to 0. This takes effect whatever en is.
  - A reset mid-stream discards in-flight beats. The first valid_out after reset comes from a beat presented at or after the first edge with rst=0.

Test Plan:
1. Defaults; X = {10, 25, 28}, Z = 21, valid_in=1, en=1 (values +10, −9, −12, −5; T = −16) → 2 edges later: valid_out=1, hard_decision=1, Y[0] = 6'b111010 (−26), Y[1] = 6'b100111 (−7), Y[2] = 6'b100100 (−4), sat_out=0.
2. X = {31, 31, 31}, Z = 31 (all −15, T = −60) → Y[i] = 6'b111111 (−31 saturated), hard_decision=1, sat_out=1, sat_count 0→1. Then clr_stats pulse → sat_count=0. Next, hold the same beat continuously with valid_in=1 → sat_count saturates at 255 and stays there.
3. X = {0, 16, 0}, Z = 16 (zeros and negative zeros) → Y all 6'b000000, hard_decision=0, sat_out=0.
4. Back-to-back beats {12, 5, 3}/Z = 10, then {1, 2, 3}/Z = 4 on consecutive edges → outputs on consecutive edges:
   - Beat 1 (T = 30): Y = {18, 25, 27}.
   - Beat 2 (T = 10): Y = {9, 8, 7}.
   - hard_decision=0 for both.
5. Stall: present a beat, drop en for 3 cycles after the first edge, change X/Z meanwhile → outputs and valid_out frozen. The original beat appears after the 2nd enabled edge. Inputs applied during the stall are ignored.
6. Reset mid-pipeline: assert rst for 1 cycle with a beat in stage 1 → valid_out=0, Y=0, sat_count=0 next cycle. The dropped beat never appears. Repeat with en=0 during rst → same result.
